// File: rtl/mul_div_if.sv
// -----------------------------------------------------------------------------
// mul_div_if
//   Request/result bundle between the register-file read stage, the
//   mul_div_unit and the writeback stage.
//
//   Request side  : in_valid, in_ready, funct3, rs1_data, rs2_data, rd_addr_in
//   Result side   : out_valid, out_ready, rd_data, rd_addr
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer holds valid and its payload
//   stable until that edge. Ready may be asserted without valid; it has no
//   effect until valid is also high.
//
//   modport master : the core side (drives requests, accepts results)
//   modport slave  : the execute unit
// -----------------------------------------------------------------------------
interface mul_div_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr_in;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd_data;
   logic [4:0]      rd_addr;

   modport master (
      output in_valid, funct3, rs1_data, rs2_data, rd_addr_in, out_ready,
      input  in_ready, out_valid, rd_data, rd_addr
   );

   modport slave (
      input  in_valid, funct3, rs1_data, rs2_data, rd_addr_in, out_ready,
      output in_ready, out_valid, rd_data, rd_addr
   );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM,
//   REMU. Operands are reduced to magnitudes at accept, the unsigned core runs
//   XLEN shift-add (multiply) or restoring shift-subtract (divide) steps, and
//   the sign is restored when the result is registered.
//
//   Ports
//     clk     : core clock, rising edge
//     rst     : asynchronous active-high reset
//     bus     : mul_div_if.slave (request and result handshakes)
//     o_state : current FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation
//
//   Build option
//     MUL_DIV_FAST_MUL_EN : when defined, all multiplies are computed in one
//                           step at accept (IDLE -> DONE); divides still
//                           iterate. Undefined by default.
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   mul_div_if.slave   bus,
   output logic [1:0] o_state
);
   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [2:0]        r_funct3;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_b;
   logic              r_neg;
   logic [CW-1:0]     r_cnt;
   // Multiply: {partial product high, multiplier bits still to consume}.
   // Divide  : {partial remainder, dividend bits shifting into quotient}.
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_rd_data;
   logic [4:0]        r_rd_addr;

   // ---------------------------------------------------------------- accept side
   logic            w_is_div;
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_neg;
   logic            w_div_zero;
   logic            w_div_ovf;
   logic [XLEN-1:0] w_special;

   always_comb begin
      w_is_div   = bus.funct3[2];
      // Multiply: MUL/MULH signed a and b, MULHSU signed a only, MULHU none.
      // Divide  : DIV/REM signed, DIVU/REMU unsigned.
      w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
      w_b_signed = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
      w_a_neg    = w_a_signed & bus.rs1_data[XLEN-1];
      w_b_neg    = w_b_signed & bus.rs2_data[XLEN-1];
      // Negating the most negative value yields the same bit pattern, which is
      // exactly its unsigned magnitude 2^(XLEN-1).
      w_a_mag    = w_a_neg ? -bus.rs1_data : bus.rs1_data;
      w_b_mag    = w_b_neg ? -bus.rs2_data : bus.rs2_data;
      // Remainder takes the dividend's sign; everything else the XOR.
      w_neg      = (w_is_div & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      w_div_zero = w_is_div & (bus.rs2_data == '0);
      w_div_ovf  = w_is_div & ~bus.funct3[0]
                 & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                 & (bus.rs2_data == {XLEN{1'b1}});
      w_special  = '0;
      if (w_div_zero)
         w_special = bus.funct3[1] ? bus.rs1_data : {XLEN{1'b1}};
      else if (w_div_ovf)
         w_special = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // ------------------------------------------------------------- one iteration
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_rem_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_acc_next;

   always_comb begin
      // Shift-add: add b to the high half when the low multiplier bit is set,
      // then shift the whole product right, the carry entering at the top.
      w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
      // Restoring divide: the remainder shifted left with the next dividend
      // bit needs XLEN+1 bits before the compare.
      w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
      w_rem_diff = w_rem_sh - {1'b0, r_b};
      w_ge       = (w_rem_sh >= {1'b0, r_b});
      if (r_funct3[2])
         w_acc_next = {(w_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_ge};
      else
         w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
   end

   // Sign restore and result select from a full unsigned product, or from a
   // {remainder, quotient} pair.
   function automatic logic [XLEN-1:0] f_finish(input logic [2:0]        f3,
                                                input logic              neg,
                                                input logic [2*XLEN-1:0] v);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   sel;
      if (f3[2]) begin
         sel      = f3[1] ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
         f_finish = neg ? -sel : sel;
      end else begin
         prod     = neg ? -v : v;
         f_finish = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   endfunction

`ifdef MUL_DIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_prod;
   always_comb begin
      w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
   end
`endif

   // ----------------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_funct3  <= '0;
         r_rd      <= '0;
         r_b       <= '0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_rd_data <= '0;
         r_rd_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_funct3 <= bus.funct3;
                  r_rd     <= bus.rd_addr_in;
                  r_b      <= w_b_mag;
                  r_neg    <= w_neg;
                  r_cnt    <= '0;
                  r_acc    <= {{XLEN{1'b0}}, w_a_mag};
                  if (w_div_zero | w_div_ovf) begin
                     r_rd_data <= w_special;
                     r_rd_addr <= bus.rd_addr_in;
                     r_state   <= S_DONE;
                  end
`ifdef MUL_DIV_FAST_MUL_EN
                  else if (!w_is_div) begin
                     r_rd_data <= f_finish(bus.funct3, w_neg, w_fast_prod);
                     r_rd_addr <= bus.rd_addr_in;
                     r_state   <= S_DONE;
                  end
`endif
                  else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(XLEN-1)) begin
                  r_rd_data <= f_finish(r_funct3, r_neg, w_acc_next);
                  r_rd_addr <= r_rd;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.rd_data   = r_rd_data;
   assign bus.rd_addr   = r_rd_addr;
   assign o_state       = r_state;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
   localparam int XLEN = 32;
`ifdef MUL_DIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;
   localparam int MAX_WAIT = 100;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                          F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                          F_REM = 3'b110, F_REMU = 3'b111;

   logic       clk;
   logic       rst;
   logic [1:0] state;
   int         errors;
   int         checks;

   mul_div_if #(.XLEN(XLEN)) bus ();

   mul_div_unit #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .o_state (state)
   );

   // ------------------------------------------------------- clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------- drivers
   task automatic drive_req(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
      bus.funct3     = f3;
      bus.rs1_data   = a;
      bus.rs2_data   = b;
      bus.rd_addr_in = rd;
      bus.in_valid   = 1'b1;
   endtask

   // Called 1 time unit after the accept edge; lat counts edges from accept
   // (inclusive) until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] data, output logic [4:0] addr,
                         output int lat);
      drive_req(f3, a, b, rd);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_valid(lat);
      data = bus.rd_data;
      addr = bus.rd_addr;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   // ---------------------------------------------------- directed vectors
   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic run_table(input vec_t v[]);
      logic [31:0] data;
      logic [4:0]  addr;
      int          lat;
      for (int i = 0; i < v.size(); i++) begin
         run_op(v[i].f3, v[i].a, v[i].b, 5'(i), data, addr, lat);
         checks++;
         if (data !== v[i].exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", v[i].name, data, v[i].exp);
         end
         checks++;
         if (addr !== 5'(i)) begin
            errors++;
            $display("FAIL %s rd_addr: got %0d want %0d", v[i].name, addr, i);
         end
         checks++;
         if (lat !== v[i].lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat);
         end
      end
   endtask

   // --------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b state=%0d want 1 0 0",
                  bus.in_ready, bus.out_valid, state);
      end
      checks++;
      if (bus.rd_data !== 32'h0 || bus.rd_addr !== 5'd0) begin
         errors++;
         $display("FAIL reset_data: got rd_data=%h rd_addr=%0d want 0 0",
                  bus.rd_data, bus.rd_addr);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      vec_t v[] = '{
         '{"mul_neg",    F_MUL,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, MUL_LAT},
         '{"mulh_neg",   F_MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, MUL_LAT},
         '{"mulhu_max",  F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT},
         '{"mulhsu",     F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT},
         '{"mulh_min",   F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT},
         '{"mul_pos",    F_MUL,    32'd6,        32'd7,        32'd42,       MUL_LAT}
      };
      run_table(v);
   endtask

   task automatic test_div();
      vec_t v[] = '{
         '{"div_neg",    F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT},
         '{"rem_neg",    F_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT},
         '{"divu",       F_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, DIV_LAT},
         '{"remu",       F_REMU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, DIV_LAT},
         '{"div_negb",   F_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT},
         '{"rem_negb",   F_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT}
      };
      run_table(v);
   endtask

   task automatic test_div_special();
      vec_t v[] = '{
         '{"div_by0",    F_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1},
         '{"divu_by0",   F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
         '{"remu_by0",   F_REMU, 32'd5,        32'd0,        32'd5,        1},
         '{"rem_by0",    F_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1},
         '{"div_ovf",    F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
         '{"rem_ovf",    F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1}
      };
      run_table(v);
   endtask

   task automatic test_reset_mid_divide();
      logic [31:0] data;
      logic [4:0]  addr;
      int          lat;
      drive_req(F_DIVU, 32'd100, 32'd7, 5'd4);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL mid_div_busy: got state=%0d want 1", state);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.rd_data !== 32'h0
          || bus.rd_addr !== 5'd0) begin
         errors++;
         $display("FAIL mid_div_reset: got in_ready=%b out_valid=%b rd_data=%h rd_addr=%0d want 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.rd_data, bus.rd_addr);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op(F_DIVU, 32'd100, 32'd7, 5'd4, data, addr, lat);
      checks++;
      if (data !== 32'd14 || addr !== 5'd4 || lat !== DIV_LAT) begin
         errors++;
         $display("FAIL after_reset_divu: got data=%0d rd=%0d lat=%0d want 14 4 %0d",
                  data, addr, lat, DIV_LAT);
      end
   endtask

   task automatic test_early_ready();
      int lat;
      bus.out_ready = 1'b1;
      drive_req(F_MUL, 32'd9, 32'd11, 5'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_valid(lat);
      checks++;
      if (lat !== MUL_LAT || bus.rd_data !== 32'd99 || bus.rd_addr !== 5'd0) begin
         errors++;
         $display("FAIL early_ready_result: got lat=%0d data=%0d rd=%0d want %0d 99 0",
                  lat, bus.rd_data, bus.rd_addr, MUL_LAT);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL early_ready_release: got out_valid=%b in_ready=%b want 0 1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      drive_req(F_MUL, 32'h1234, 32'h10, 5'd5);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_valid(lat);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.rd_data !== 32'h12340 || bus.rd_addr !== 5'd5
             || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_c%0d: got out_valid=%b data=%h rd=%0d in_ready=%b want 1 00012340 5 0",
                     c, bus.out_valid, bus.rd_data, bus.rd_addr, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0 1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [36:0] exp_q[$];
      logic [36:0] exp;
      int          lat;
      exp_q.push_back({5'd3, 32'd9});
      exp_q.push_back({5'd9, 32'd16});
      drive_req(F_MUL, 32'd3, 32'd3, 5'd3);
      @(posedge clk);
      #1;
      // Second request stays pending with in_valid held high.
      drive_req(F_MUL, 32'd4, 32'd4, 5'd9);
      for (int n = 0; n < 2; n++) begin
         wait_valid(lat);
         checks++;
         if (n == 0 && bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending: got in_ready=%b want 0", bus.in_ready);
         end
         exp = exp_q.pop_front();
         checks++;
         if ({bus.rd_addr, bus.rd_data} !== exp) begin
            errors++;
            $display("FAIL b2b_%0d: got rd=%0d data=%0d want rd=%0d data=%0d",
                     n, bus.rd_addr, bus.rd_data, exp[36:32], exp[31:0]);
         end
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.out_ready = 1'b0;
         if (n == 0) begin
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle: got in_ready=%b out_valid=%b want 1 0",
                        bus.in_ready, bus.out_valid);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
         end
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_queue: got %0d left want 0", exp_q.size());
      end
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      errors         = 0;
      checks         = 0;
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.funct3     = 3'b000;
      bus.rs1_data   = 32'h0;
      bus.rs2_data   = 32'h0;
      bus.rd_addr_in = 5'd0;
      test_reset();
      test_mul();
      test_div();
      test_div_special();
      test_reset_mid_divide();
      test_early_ready();
      test_backpressure();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
